// File: rtl/ctr_seq_checker.sv
// ---------------------------------------------------------------------------
// ctr_seq_checker
//   Receive-side checker for a free-running WIDTH-bit counter stream.
//   It samples the count and acquires lock after LOCK_CNT consecutive correct
//   increments. While locked it flags every sequence break and counts it in a
//   saturating error counter. It also pulses on an all-ones -> 0 wrap.
//   Every output is registered and appears one cycle after the sample edge.
//
// Optional feature (macro CTR_CHK_STALL_EN):
//   Adds the output `stall`. A valid sample equal to the previous one pulses
//   stall and leaves the state, good-run counter and lock untouched. Without
//   the macro, a repeated value is an ordinary mismatch.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous reset, active-high
//   cnt_in   in   [WIDTH-1:0] count sample under check
//   cnt_vld  in   cnt_in valid this cycle
//   clr_err  in   synchronous clear of err_cnt (wins over an increment)
//   locked   out  checker is in LOCKED state
//   seq_err  out  one-cycle pulse: sequence break while LOCKED
//   wrap     out  one-cycle pulse: valid all-ones -> 0 transition
//   err_cnt  out  [ERR_W-1:0] saturating count of seq_err events
//   stall    out  (CTR_CHK_STALL_EN only) one-cycle pulse on a repeated value
// ---------------------------------------------------------------------------
module ctr_seq_checker #(
   parameter int WIDTH    = 11,
   parameter int LOCK_CNT = 4,
   parameter int ERR_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] cnt_in,
   input  logic             cnt_vld,
   input  logic             clr_err,
   output logic             locked,
   output logic             seq_err,
   output logic             wrap,
`ifdef CTR_CHK_STALL_EN
   output logic             stall,
`endif
   output logic [ERR_W-1:0] err_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACQ,
      S_LOCK
   } state_t;

   localparam logic [7:0] LOCK_V = 8'(LOCK_CNT);

   state_t           state_q;
   logic [WIDTH-1:0] prev_q;
   logic [7:0]       run_q;
   logic             locked_q;
   logic             seq_err_q;
   logic             wrap_q;
   logic [ERR_W-1:0] err_cnt_q;

   logic [WIDTH-1:0] expected_d;
   logic [7:0]       run_d;
   logic [ERR_W-1:0] err_cnt_d;
   logic             good;
   logic             wrap_hit;
   logic             stall_hit;

   // The carry out of the top bit is discarded, so all-ones + 1 expects 0.
   assign expected_d = prev_q + 1'b1;
   assign good       = (cnt_in == expected_d);
   assign wrap_hit   = (&prev_q) && (cnt_in == '0);
   assign run_d      = run_q + 8'd1;
   // Saturate: once all ones, further errors leave the count in place.
   assign err_cnt_d  = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;

`ifdef CTR_CHK_STALL_EN
   logic stall_q;
   assign stall_hit = (cnt_in == prev_q);
   assign stall     = stall_q;
`else
   assign stall_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         prev_q    <= '0;
         run_q     <= '0;
         locked_q  <= 1'b0;
         seq_err_q <= 1'b0;
         wrap_q    <= 1'b0;
         err_cnt_q <= '0;
`ifdef CTR_CHK_STALL_EN
         stall_q   <= 1'b0;
`endif
      end else begin
         seq_err_q <= 1'b0;
         wrap_q    <= 1'b0;
`ifdef CTR_CHK_STALL_EN
         stall_q   <= 1'b0;
`endif
         if (clr_err) begin
            err_cnt_q <= '0;
         end
         if (cnt_vld) begin
            prev_q <= cnt_in;
            unique case (state_q)
               S_IDLE: begin
                  // First sample only seeds prev; nothing to compare against.
                  run_q   <= '0;
                  state_q <= S_ACQ;
               end
               S_ACQ: begin
                  wrap_q <= wrap_hit;
                  if (stall_hit) begin
`ifdef CTR_CHK_STALL_EN
                     stall_q <= 1'b1;
`endif
                  end else if (good) begin
                     run_q <= run_d;
                     if (run_d == LOCK_V) begin
                        state_q  <= S_LOCK;
                        locked_q <= 1'b1;
                     end
                  end else begin
                     run_q <= '0;
                  end
               end
               S_LOCK: begin
                  wrap_q <= wrap_hit;
                  if (stall_hit) begin
`ifdef CTR_CHK_STALL_EN
                     stall_q <= 1'b1;
`endif
                  end else if (!good) begin
                     seq_err_q <= 1'b1;
                     locked_q  <= 1'b0;
                     run_q     <= '0;
                     state_q   <= S_ACQ;
                     if (!clr_err) begin
                        err_cnt_q <= err_cnt_d;
                     end
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign locked  = locked_q;
   assign seq_err = seq_err_q;
   assign wrap    = wrap_q;
   assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ctr_seq_checker.sv
`timescale 1ns/1ps
module tb_ctr_seq_checker;

   localparam int WIDTH = 11;
   localparam int ERR_W = 2;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] cnt_in;
   logic             cnt_vld;
   logic             clr_err;
   logic             locked;
   logic             seq_err;
   logic             wrap;
   logic [ERR_W-1:0] err_cnt;
`ifdef CTR_CHK_STALL_EN
   logic             stall;
`endif

   ctr_seq_checker #(.WIDTH(WIDTH), .LOCK_CNT(4), .ERR_W(ERR_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .cnt_in  (cnt_in),
      .cnt_vld (cnt_vld),
      .clr_err (clr_err),
      .locked  (locked),
      .seq_err (seq_err),
      .wrap    (wrap),
`ifdef CTR_CHK_STALL_EN
      .stall   (stall),
`endif
      .err_cnt (err_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   typedef struct {
      logic             lk;
      logic             se;
      logic             wr;
      logic [ERR_W-1:0] ec;
      logic             st;
      string            nm;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Monitor: outputs are meaningful every cycle, so one entry is consumed per
   // falling edge once the driver has pushed it.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic bad;
         e = sb.pop_front();
         bad = (locked !== e.lk) || (seq_err !== e.se) || (wrap !== e.wr) ||
               (err_cnt !== e.ec);
`ifdef CTR_CHK_STALL_EN
         bad = bad || (stall !== e.st);
`endif
         n_tests++;
         if (bad) begin
            n_fail++;
            $display("FAIL %s: got locked=%0b seq_err=%0b wrap=%0b err_cnt=%0d, expected locked=%0b seq_err=%0b wrap=%0b err_cnt=%0d",
                     e.nm, locked, seq_err, wrap, err_cnt, e.lk, e.se, e.wr, e.ec);
`ifdef CTR_CHK_STALL_EN
            $display("FAIL %s: got stall=%0b, expected stall=%0b", e.nm, stall, e.st);
`endif
         end
      end
   end

   // Apply one cycle of input and queue the hand-computed outputs that must
   // be visible after that clock edge.
   task automatic step(input logic r, input logic v, input int c, input logic clr,
                       input logic el, input logic es, input logic ew,
                       input int ee, input logic est, input string nm);
      exp_t e;
      rst     = r;
      cnt_vld = v;
      cnt_in  = WIDTH'(c);
      clr_err = clr;
      @(posedge clk);
      e.lk = el; e.se = es; e.wr = ew; e.ec = ERR_W'(ee); e.st = est; e.nm = nm;
      sb.push_back(e);
      #1;
   endtask

   int exp_err[5] = '{1, 2, 3, 3, 0};

   initial begin
      int p;
      rst = 1'b1; cnt_vld = 1'b0; cnt_in = '0; clr_err = 1'b0;

      // 1: reset state, then lock on 0..4
      step(1, 0, 0, 0,    0, 0, 0, 0, 0, "t1_reset");
      step(0, 1, 0, 0,    0, 0, 0, 0, 0, "t1_s0_idle");
      step(0, 1, 1, 0,    0, 0, 0, 0, 0, "t1_s1");
      step(0, 1, 2, 0,    0, 0, 0, 0, 0, "t1_s2");
      step(0, 1, 3, 0,    0, 0, 0, 0, 0, "t1_s3");
      step(0, 1, 4, 0,    1, 0, 0, 0, 0, "t1_s4_lock");

      // 2: jump to 0 from 5 is not a wrap; locked wrap 2047 -> 0 is
      step(1, 0, 0, 0,    0, 0, 0, 0, 0, "t2_reset");
      step(0, 1, 5, 0,    0, 0, 0, 0, 0, "t2_s5_idle");
      step(0, 1, 0, 0,    0, 0, 0, 0, 0, "t2_jump0_nowrap");
      step(0, 1, 2041, 0, 0, 0, 0, 0, 0, "t2_s2041");
      step(0, 1, 2042, 0, 0, 0, 0, 0, 0, "t2_s2042");
      step(0, 1, 2043, 0, 0, 0, 0, 0, 0, "t2_s2043");
      step(0, 1, 2044, 0, 0, 0, 0, 0, 0, "t2_s2044");
      step(0, 1, 2045, 0, 1, 0, 0, 0, 0, "t2_s2045_lock");
      step(0, 1, 2046, 0, 1, 0, 0, 0, 0, "t2_s2046");
      step(0, 1, 2047, 0, 1, 0, 0, 0, 0, "t2_s2047");
      step(0, 1, 0, 0,    1, 0, 1, 0, 0, "t2_s0_wrap");
      step(0, 1, 1, 0,    1, 0, 0, 0, 0, "t2_s1_nowrap");

      // 3: break while locked, then relock after 4 good increments
      step(1, 0, 0, 0,    0, 0, 0, 0, 0, "t3_reset");
      step(0, 1, 96, 0,   0, 0, 0, 0, 0, "t3_s96_idle");
      step(0, 1, 97, 0,   0, 0, 0, 0, 0, "t3_s97");
      step(0, 1, 98, 0,   0, 0, 0, 0, 0, "t3_s98");
      step(0, 1, 99, 0,   0, 0, 0, 0, 0, "t3_s99");
      step(0, 1, 100, 0,  1, 0, 0, 0, 0, "t3_s100_lock");
      step(0, 1, 101, 0,  1, 0, 0, 0, 0, "t3_s101");
      step(0, 1, 105, 0,  0, 1, 0, 1, 0, "t3_s105_err");
      step(0, 1, 106, 0,  0, 0, 0, 1, 0, "t3_s106");
      step(0, 1, 107, 0,  0, 0, 0, 1, 0, "t3_s107");
      step(0, 1, 108, 0,  0, 0, 0, 1, 0, "t3_s108");
      step(0, 1, 109, 0,  1, 0, 0, 1, 0, "t3_s109_relock");

      // 4: gaps are tolerated; reset mid-stream drops lock and clears err_cnt
      step(1, 0, 0, 0,    0, 0, 0, 0, 0, "t4_reset");
      step(0, 1, 196, 0,  0, 0, 0, 0, 0, "t4_s196_idle");
      step(0, 1, 197, 0,  0, 0, 0, 0, 0, "t4_s197");
      step(0, 1, 198, 0,  0, 0, 0, 0, 0, "t4_s198");
      step(0, 1, 199, 0,  0, 0, 0, 0, 0, "t4_s199");
      step(0, 1, 200, 0,  1, 0, 0, 0, 0, "t4_s200_lock");
      step(0, 0, 7, 0,    1, 0, 0, 0, 0, "t4_gap1");
      step(0, 0, 0, 0,    1, 0, 0, 0, 0, "t4_gap2");
      step(0, 0, 555, 0,  1, 0, 0, 0, 0, "t4_gap3");
      step(0, 1, 201, 0,  1, 0, 0, 0, 0, "t4_s201");
      step(0, 1, 202, 0,  1, 0, 0, 0, 0, "t4_s202");
      step(0, 1, 210, 0,  0, 1, 0, 1, 0, "t4_s210_err");
      step(0, 1, 211, 0,  0, 0, 0, 1, 0, "t4_s211");
      step(1, 1, 212, 0,  0, 0, 0, 0, 0, "t4_mid_reset");

      // 5: 2-bit error counter saturates; clr_err wins on the 5th error
      step(0, 1, 0, 0,    0, 0, 0, 0, 0, "t5_s0_idle");
      p = 0;
      for (int k = 0; k < 5; k++) begin
         for (int i = 1; i <= 4; i++) begin
            p++;
            step(0, 1, p, 0, (i == 4), 0, 0, (k == 0) ? 0 : exp_err[k-1], 0,
                 $sformatf("t5_relock_k%0d_i%0d", k, i));
         end
         p += 10;
         step(0, 1, p, (k == 4), 0, 1, 0, exp_err[k], 0, $sformatf("t5_err_k%0d", k));
      end

      // 6: repeated value while locked
      step(1, 0, 0, 0,    0, 0, 0, 0, 0, "t6_reset");
      step(0, 1, 296, 0,  0, 0, 0, 0, 0, "t6_s296_idle");
      step(0, 1, 297, 0,  0, 0, 0, 0, 0, "t6_s297");
      step(0, 1, 298, 0,  0, 0, 0, 0, 0, "t6_s298");
      step(0, 1, 299, 0,  0, 0, 0, 0, 0, "t6_s299");
      step(0, 1, 300, 0,  1, 0, 0, 0, 0, "t6_s300_lock");
      step(0, 1, 301, 0,  1, 0, 0, 0, 0, "t6_s301");
`ifdef CTR_CHK_STALL_EN
      step(0, 1, 301, 0,  1, 0, 0, 0, 1, "t6_s301_repeat_stall");
      step(0, 1, 302, 0,  1, 0, 0, 0, 0, "t6_s302");
`else
      step(0, 1, 301, 0,  0, 1, 0, 1, 0, "t6_s301_repeat_err");
      step(0, 1, 302, 0,  0, 0, 0, 1, 0, "t6_s302");
`endif

      cnt_vld = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
